div_issue_ctrl: RTL

- EX-stage initiator for the iterative 64-bit divider: detects M-extension DIV/REM ops, launches them over the divider's ready/busy/finish handshake and stalls the pipeline while the divide runs.
- Sign- or zero-extends 32-bit W-variant operands, because the divider treats operands as full 64-bit values.
- Holds operands and opcode stable for the whole operation, because the divider's result mux and divide-by-zero override read them combinationally.
- Captures the result and hands it to writeback with a valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/div_operand_ext.sv | 20 ++
 rtl/div_issue_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op_f3 encodings, decode helpers and controller states shared by the mul/div paths.
package muldiv_pkg;
    localparam int OP_W = 10;
    localparam logic [OP_W-1:0] INST_DIV   = 10'h19C;
    localparam logic [OP_W-1:0] INST_DIVU  = 10'h19D;
    localparam logic [OP_W-1:0] INST_REM   = 10'h19E;
    localparam logic [OP_W-1:0] INST_REMU  = 10'h19F;
    localparam logic [OP_W-1:0] INST_DIVW  = 10'h1DC;
    localparam logic [OP_W-1:0] INST_DIVUW = 10'h1DD;
    localparam logic [OP_W-1:0] INST_REMW  = 10'h1DE;
    localparam logic [OP_W-1:0] INST_REMUW = 10'h1DF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} div_state_e;

    function automatic logic is_div_op(input logic [OP_W-1:0] f);
        return f inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU,
                         INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    endfunction

    function automatic logic is_word_op(input logic [OP_W-1:0] f);
        return f inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    endfunction
endpackage

// File: rtl/div_operand_ext.sv
// div_operand_ext: widens 32-bit W-variant operands (signed ops sign-extend, unsigned ops zero-extend).
module div_operand_ext
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [OP_W-1:0] op_f3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b
);
    logic word, sgn;
    assign word = is_word_op(op_f3);
    assign sgn  = ~op_f3[0];
    always_comb begin
        op_a = !word ? rs1 : sgn ? {{(XLEN-32){rs1[31]}}, rs1[31:0]} : {{(XLEN-32){1'b0}}, rs1[31:0]};
        op_b = !word ? rs2 : sgn ? {{(XLEN-32){rs2[31]}}, rs2[31:0]} : {{(XLEN-32){1'b0}}, rs2[31:0]};
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: launches DIV/REM ops on the iterative divider, stalls EX while it runs,
// drains flushed ops and hands results to writeback.
module div_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int OPF3_W      = 10,
    parameter int TIMEOUT_CYC = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [OPF3_W-1:0] ex_op_f3,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              ex_stall,
    output logic              div_ready,
    output logic [XLEN-1:0]   div_dividend,
    output logic [XLEN-1:0]   div_diviser,
    output logic [OPF3_W-1:0] div_op_f3,
    input  logic              div_busy,
    input  logic              div_finish,
    input  logic [XLEN-1:0]   div_rem_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic              wb_ready,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    div_state_e      state;
    logic            killed, is_div, accept, timeout, drop;
    logic [CW-1:0]   wd_cnt;
    logic [XLEN-1:0] ext_a, ext_b;

    div_operand_ext #(.XLEN(XLEN)) u_ext (
        .op_f3(ex_op_f3),
        .rs1  (ex_rs1),
        .rs2  (ex_rs2),
        .op_a (ext_a),
        .op_b (ext_b)
    );

    assign is_div    = ex_valid & is_div_op(ex_op_f3);
    assign accept    = (state == IDLE) & is_div & ~flush;
    assign timeout   = (state == WAIT) & ~div_finish & (wd_cnt == CW'(TIMEOUT_CYC - 1));
    assign drop      = killed | flush;
    assign div_ready = state == ISSUE;
    assign wb_valid  = state == DONE;

    // A killed op is still draining, so the pipeline only stalls if it offers another divide.
    always_comb ex_stall = (state == IDLE) ? accept : (state == WAIT && killed) ? is_div : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            killed       <= 1'b0;
            wd_cnt       <= '0;
            timeout_err  <= 1'b0;
            div_dividend <= '0;
            div_diviser  <= '0;
            div_op_f3    <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (accept) begin
                    div_dividend <= ext_a;
                    div_diviser  <= ext_b;
                    div_op_f3    <= ex_op_f3;
                    wb_rd        <= ex_rd;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    killed <= flush;
                    state  <= WAIT;
                end
                WAIT: if (div_finish) begin
                    if (!drop) wb_data <= div_rem_data;
                    state  <= drop ? IDLE : DONE;
                    killed <= 1'b0;
                end else if (timeout) begin
                    timeout_err <= 1'b1;
                    killed      <= 1'b0;
                    state       <= IDLE;
                end else begin
                    killed <= drop;
                end
                DONE: if (wb_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_issue_when_busy: assert property (@(posedge clk) disable iff (rst) !(div_ready && div_busy));
endmodule
